// File: rtl/conv_encoder_packer_pkg.sv
`default_nettype none
// ============================================================================
// Package : vd_pkg
// Brief   : Shared widths, generator defaults, encoder state encoding and the
//           bit-pair helper for the convolutional encoder/packer.
// Rev     : 1.0  initial release
// ============================================================================
package vd_pkg;

    localparam int MSG_W  = 8;
    localparam int CODE_W = 16;

    // Octal 7 / octal 5 generators, K=3
    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        HOLD   = 2'd2
    } enc_state_e;

    // Output pair for register r = {u, s1, s0}: {parity(r&g0), parity(r&g1)}
    function automatic logic [1:0] conv_pair(input logic [2:0] r,
                                             input logic [2:0] g0,
                                             input logic [2:0] g1);
        return {^(r & g0), ^(r & g1)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_encoder_packer_if.sv
`default_nettype none
// ============================================================================
// Interface : conv_encoder_packer_if
// Brief     : Message-in and codeword-out handshakes of the encoder/packer.
//             master = the encoder block, slave = the source/sink around it.
// Rev       : 1.0  initial release
// ============================================================================
interface conv_encoder_packer_if;
    import vd_pkg::*;

    logic [MSG_W-1:0]  msg_in;
    logic              msg_valid;
    logic              msg_ready;
    logic [CODE_W-1:0] code_out;
    logic              code_valid;
    logic              code_ready;
    logic              busy;

    modport master (
        input  msg_in, msg_valid, code_ready,
        output msg_ready, code_out, code_valid, busy
    );

    modport slave (
        output msg_in, msg_valid, code_ready,
        input  msg_ready, code_out, code_valid, busy
    );

endinterface
`default_nettype wire

// File: rtl/conv_encoder_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module : enc_msg_fifo
// Brief  : Small synchronous message FIFO. full is registered from the next
//          count so the upstream ready has no combinational input path.
// Rev    : 1.0  initial release
// ============================================================================
module enc_msg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full_q;
    assign w_pop  = pop & (count_q != '0);

    // Occupancy after this cycle; simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers, count and registered full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/conv_encoder_packer.sv
`default_nettype none
// ============================================================================
// Module : conv_encoder_packer
// Brief  : Rate-1/2 K=3 convolutional encoder. Serially encodes 8-bit
//          messages MSB first into 16-bit codewords (pair 0 in [15:14]) and
//          presents them on a valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module conv_encoder_packer
    import vd_pkg::*;
#(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [2:0] G0         = G0_DEF,
    parameter logic [2:0] G1         = G1_DEF
) (
    input wire logic              clk,
    input wire logic              rst_n,
    conv_encoder_packer_if.master bus
);

    localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_BIT = 3'(MSG_W - 1);

    enc_state_e        state_q;
    logic [MSG_W-1:0]  msg_q;
    logic              s1_q;
    logic              s0_q;
    logic [2:0]        bit_cnt_q;
    logic [CODE_W-1:0] shadow_q;
    logic [CODE_W-1:0] code_q;
    logic              code_valid_q;
    logic              busy_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [MSG_W-1:0]  fifo_dout;
    logic [CNT_W-1:0]  fifo_count;

    logic              w_avail;
    logic              w_u;
    logic [1:0]        w_pair;

    enc_msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.msg_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign w_avail   = ~fifo_empty & (fifo_count != '0);
    assign fifo_push = bus.msg_valid & ~fifo_full;
    // Pop when starting from idle, or when the held codeword is taken
    assign fifo_pop  = w_avail & ((state_q == IDLE) ||
                                  ((state_q == HOLD) && bus.code_ready));

    assign w_u    = msg_q[MSG_W-1];
    assign w_pair = conv_pair({w_u, s1_q, s0_q}, G0, G1);

    // Encoder FSM with registered codeword, valid and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            msg_q        <= '0;
            s1_q         <= 1'b0;
            s0_q         <= 1'b0;
            bit_cnt_q    <= '0;
            shadow_q     <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_avail) begin
                        msg_q     <= fifo_dout;
                        s1_q      <= 1'b0;
                        s0_q      <= 1'b0;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ENCODE;
                    end
                end
                ENCODE: begin
                    msg_q     <= {msg_q[MSG_W-2:0], 1'b0};
                    s1_q      <= w_u;
                    s0_q      <= s1_q;
                    shadow_q  <= {shadow_q[CODE_W-3:0], w_pair};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        // Publish the finished word in one step so code_out
                        // only ever changes on entry to HOLD
                        code_q       <= {shadow_q[CODE_W-3:0], w_pair};
                        code_valid_q <= 1'b1;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.code_ready) begin
                        code_valid_q <= 1'b0;
                        if (w_avail) begin
                            msg_q     <= fifo_dout;
                            s1_q      <= 1'b0;
                            s0_q      <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= ENCODE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    code_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.msg_ready  = ~fifo_full;
    assign bus.code_out   = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_encoder_packer
// Brief  : Directed bench for conv_encoder_packer with a codeword scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_conv_encoder_packer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    conv_encoder_packer_if bus_if ();

    conv_encoder_packer #(
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] sb [$];
    logic        b2b_on   = 1'b0;
    int          b2b_prev = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: c_hi = u^s1^s0, c_lo = u^s0, state cleared per message
    function automatic logic [15:0] enc_model(input logic [7:0] m);
        logic [15:0] res;
        logic        p1;
        logic        p2;
        logic        u;
        res = '0;
        p1  = 1'b0;
        p2  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            u   = m[i];
            res = {res[13:0], u ^ p1 ^ p2, u ^ p2};
            p2  = p1;
            p1  = u;
        end
        return res;
    endfunction

    // Scoreboard consumer: every accepted codeword is compared in order
    always @(negedge clk) begin
        logic [15:0] exp_w;
        if (rst_n && bus_if.code_valid && bus_if.code_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("codeword", 32'(bus_if.code_out), 32'(exp_w));
            end
            if (b2b_on) begin
                if (b2b_prev >= 0) check("b2b_spacing", 32'(cyc - b2b_prev), 32'd9);
                b2b_prev = cyc;
            end
        end
    end

    // Offer a message until accepted; returns 1ns after the accepting edge
    task automatic send_msg(input logic [7:0] m, input bit keep_valid);
        logic rdy;
        bit   done;
        done = 0;
        bus_if.msg_in    = m;
        bus_if.msg_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            rdy = bus_if.msg_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1;
                sb.push_back(enc_model(m));
            end
        end
        #1;
        if (!done) check("send_timeout", 32'd0, 32'd1);
        if (!keep_valid) bus_if.msg_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 400 && sb.size() != 0; t++) begin
            @(posedge clk);
            #2;
        end
        repeat (2) @(posedge clk);
        #1;
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bus_if.msg_in     = '0;
        bus_if.msg_valid  = 1'b0;
        bus_if.code_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_code_out",   32'(bus_if.code_out),   32'h0);
        check("rst_code_valid", 32'(bus_if.code_valid), 32'd0);
        check("rst_msg_ready",  32'(bus_if.msg_ready),  32'd1);
        check("rst_busy",       32'(bus_if.busy),       32'd0);
        repeat (2) @(posedge clk);
        #1;

        // 8'h80 -> EC00, valid exactly 9 cycles after acceptance
        check("model_80", 32'(enc_model(8'h80)), 32'hEC00);
        send_msg(8'h80, 0);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            check("latency_valid", 32'(bus_if.code_valid), (i == 9) ? 32'd1 : 32'd0);
        end
        check("latency_code", 32'(bus_if.code_out), 32'hEC00);
        drain("drain_80");

        // 8'hFF -> DAAA, then all-zero message still delivered
        send_msg(8'hFF, 0);
        drain("drain_ff");
        send_msg(8'h00, 0);
        drain("drain_00");

        // Backpressure: fill HOLD + FIFO, fourth message held off
        bus_if.code_ready = 1'b0;
        send_msg(8'h80, 0);
        send_msg(8'hFF, 0);
        send_msg(8'h01, 0);
        check("bp_ready_low", 32'(bus_if.msg_ready), 32'd0);
        bus_if.msg_in    = 8'h5A;
        bus_if.msg_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("bp_hold_code",  32'(bus_if.code_out),   32'hEC00);
        repeat (8) @(posedge clk);
        #1;
        check("bp_ready_held", 32'(bus_if.msg_ready),  32'd0);
        check("bp_valid_held", 32'(bus_if.code_valid), 32'd1);
        check("bp_code_held",  32'(bus_if.code_out),   32'hEC00);
        check("bp_busy",       32'(bus_if.busy),       32'd1);
        bus_if.code_ready = 1'b1;
        send_msg(8'h5A, 0);
        drain("drain_bp");

        // Back-to-back with msg_valid always high
        b2b_prev = -1;
        b2b_on   = 1'b1;
        send_msg(8'h3C, 1);
        send_msg(8'hA5, 1);
        send_msg(8'h81, 1);
        send_msg(8'h7E, 1);
        send_msg(8'h12, 1);
        send_msg(8'hC9, 0);
        drain("drain_b2b");
        b2b_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset during ENCODE with one message queued
        send_msg(8'hFF, 0);
        send_msg(8'h01, 0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_code_out",   32'(bus_if.code_out),   32'h0);
        check("arst_code_valid", 32'(bus_if.code_valid), 32'd0);
        check("arst_msg_ready",  32'(bus_if.msg_ready),  32'd1);
        check("arst_busy",       32'(bus_if.busy),       32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_valid", 32'(bus_if.code_valid), 32'd0);
        check("post_rst_busy",  32'(bus_if.busy),       32'd0);

        // Push in the same cycle that HOLD pops, FIFO count 1
        bus_if.code_ready = 1'b0;
        send_msg(8'h80, 0);
        send_msg(8'hFF, 0);
        for (int t = 0; t < 50 && !bus_if.code_valid; t++) @(negedge clk);
        check("pp_in_hold", 32'(bus_if.code_valid), 32'd1);
        @(posedge clk);
        #1;
        bus_if.code_ready = 1'b1;
        send_msg(8'h01, 0);
        check("pp_count",     32'(dut.u_fifo.count),  32'd1);
        check("pp_msg_ready", 32'(bus_if.msg_ready),  32'd1);
        drain("drain_pp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_encoder_packer.md
# conv_encoder_packer

Rate-1/2, constraint-length-3 convolutional encoder that turns 8-bit messages into 16-bit codewords of 8 bit-pairs, in the exact packing the Viterbi decoder's input stage consumes (bit-pair 0 in [15:14] … bit-pair 7 in [1:0]). Messages are accepted through a small FIFO and encoded serially, one bit per cycle, MSB first. Codewords leave through a valid/ready handshake. The block is the transmit-side counterpart of the decoder and serves as the bench's stimulus source in loopback.

## Interface
- FIFO_DEPTH, 2, message FIFO entries (power of two, ≥2)
- G0, 3'b111, generator for the high bit of each pair (octal 7)
- G1, 3'b101, generator for the low bit of each pair (octal 5)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- msg_in  in  8  message, bit 7 encoded first
- msg_valid  in  1  msg_in valid
- msg_ready  out  1  FIFO not full; transfer when msg_valid & msg_ready
- code_out  out  16  codeword, pair k in [15-2k:14-2k]
- code_valid  out  1  code_out valid, held until accepted
- code_ready  in  1  sink accepts; transfer when code_valid & code_ready
- busy  out  1  high in ENCODE or HOLD

## Operation
- Encoder memory {s1,s0}, where s1 is the previous bit. It is cleared to 00 when each message is loaded, so every codeword starts from state 0 and decodes independently.
- For input bit u, the register is r = {u,s1,s0}. The output pair is {^(r & G0), ^(r & G1)}. Then s1←u and s0←s1. With defaults: c_hi = u^s1^s0, c_lo = u^s0.
- States:
  - IDLE → ENCODE when the FIFO is non-empty. The message is popped, loaded into the shift register, memory is cleared, and bit_cnt is set to 0.
  - ENCODE: one bit per cycle. The pair is shifted into the low end of code_out's shadow register. After the 8th bit (bit_cnt=7) → HOLD.
  - HOLD: code_valid=1 and code_out is stable. On code_ready, if the FIFO is non-empty, pop and → ENCODE in the same cycle; otherwise → IDLE.
- FIFO:
  - Push on msg_valid & msg_ready.
  - Pop per the states above.
  - A push and a pop in the same cycle both take effect and the count is unchanged.
  - msg_ready = (count != FIFO_DEPTH), registered from the count; no combinational path from code_ready.
  - msg_valid while full: the message is not accepted, nothing is dropped, and the source holds it.
- An all-zero message produces 16'h0000. It is still delivered with code_valid=1; the block does not filter it.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: code_out=16'h0000, code_valid=0, msg_ready=1, busy=0, FIFO empty, state IDLE, memory 00.
- Reset mid-operation (ENCODE/HOLD) clears all of the above immediately. The in-flight codeword and the FIFO contents are discarded.
- Latency: for a message accepted at edge N into an empty, idle block:
  - pop at edge N+1;
  - encode at edges N+2…N+9;
  - code_valid is high after edge N+9, i.e. 9 cycles after acceptance.
- Throughput: with code_ready tied to 1 and the FIFO kept fed, one codeword per 9 cycles (8 ENCODE + 1 HOLD).
- code_out and code_valid are registered and do not change while code_valid=1 and code_ready=0.

## Structure
- Shared package vd_pkg holds:
  - state enum {IDLE, ENCODE, HOLD};
  - default generator constants G0_DEF and G1_DEF;
  - MSG_W=8 and CODE_W=16.
- One sub-module: enc_msg_fifo, a synchronous FIFO with parameters WIDTH and DEPTH, ports push, pop, din, dout, full, empty, and count. The encoder FSM and the pair datapath stay in the top module.

## Test plan
- Reset, then send msg 8'h80 with code_ready=1. Required: code_out=16'hEC00 and code_valid high exactly 9 cycles after acceptance.
- Send msg 8'hFF → 16'hDAAA. Then 8'h00 → 16'h0000 with code_valid=1, which confirms memory is cleared between packets.
- Hold code_ready=0 and push 8'h80, 8'hFF, 8'h01. Required:
  - msg_ready drops after the 3rd accept (1 in HOLD + 2 in FIFO);
  - a 4th message is held off;
  - after releasing code_ready, codewords come out in order EC00, DAAA, 0003.
- Back-to-back with code_ready=1 and msg_valid always high: consecutive code_valid pulses exactly 9 cycles apart, no gaps or duplicates.
- Assert rst_n low during ENCODE of 8'hFF with one message queued. Required: all outputs return to reset values asynchronously, and no codeword appears after release until a new message is sent.
- Push in the same cycle HOLD pops, with FIFO count 1: count stays 1 and the next two codewords are correct and in order.
